// File: rtl/k8088_bus.sv
// k8088 core to byte-wide memory bridge with bus watchdog.
// Optional one-entry read hit buffer: `K8088_BUS_HIT_EN.
module k8088_bus #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [19:0] cpu_address,
   input  logic [7:0]  cpu_out,
   input  logic        cpu_we,
   output logic [7:0]  cpu_in,
   output logic        chipen,
   output logic [19:0] mem_address,
   output logic [7:0]  mem_wdata,
   output logic        mem_we,
   output logic        mem_req,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ack,
   output logic        bus_error
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RUN
   } state_t;

   localparam logic [15:0] TMO = 16'(TIMEOUT);

   state_t      state, state_d;
   logic [15:0] cnt, cnt_d, cnt_inc;
   logic        chipen_d, req_d, we_d, err_d;
   logic [19:0] addr_d;
   logic [7:0]  wdata_d, cin_d;
   logic        tmo;
   logic        hit;
   logic [7:0]  hit_data;

   assign cnt_inc = cnt + 16'd1;
   assign tmo     = (TMO != 16'd0) && (cnt_inc == TMO);

`ifdef K8088_BUS_HIT_EN
   logic        hv;
   logic [19:0] ha;
   logic [7:0]  hd;

   assign hit      = !cpu_we && hv && (cpu_address == ha);
   assign hit_data = hd;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hv <= 1'b0;
         ha <= '0;
         hd <= '0;
      end else if (state == IDLE) begin
         if (cpu_we && (cpu_address == ha))
            hd <= cpu_out;
      end else if (state == WAIT) begin
         if (mem_ack) begin
            if (!mem_we) begin
               hv <= 1'b1;
               ha <= mem_address;
               hd <= mem_rdata;
            end
         end else if (tmo) begin
            hv <= 1'b0;
         end
      end
   end
`else
   assign hit      = 1'b0;
   assign hit_data = 8'h00;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         chipen      <= 1'b0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_address <= '0;
         mem_wdata   <= '0;
         cpu_in      <= 8'h00;
         bus_error   <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         chipen      <= chipen_d;
         mem_req     <= req_d;
         mem_we      <= we_d;
         mem_address <= addr_d;
         mem_wdata   <= wdata_d;
         cpu_in      <= cin_d;
         bus_error   <= err_d;
      end
   end

   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      chipen_d = 1'b0;
      req_d    = mem_req;
      we_d     = mem_we;
      addr_d   = mem_address;
      wdata_d  = mem_wdata;
      cin_d    = cpu_in;
      err_d    = bus_error;
      unique case (state)
         IDLE: begin
            addr_d  = cpu_address;
            wdata_d = cpu_out;
            we_d    = cpu_we;
            cnt_d   = '0;
            if (hit) begin
               cin_d    = hit_data;
               chipen_d = 1'b1;
               state_d  = RUN;
            end else begin
               req_d   = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            // ack takes priority over a watchdog expiring the same cycle
            if (mem_ack) begin
               req_d    = 1'b0;
               chipen_d = 1'b1;
               state_d  = RUN;
               if (!mem_we)
                  cin_d = mem_rdata;
            end else if (tmo) begin
               cnt_d    = cnt_inc;
               req_d    = 1'b0;
               cin_d    = 8'hFF;
               err_d    = 1'b1;
               chipen_d = 1'b1;
               state_d  = RUN;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         RUN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_k8088_bus.sv
// Randomized bench for k8088_bus against a transaction-level model.
// Hit-buffer expectations follow `K8088_BUS_HIT_EN.
module tb_k8088_bus;

   localparam int TMO = 8;

   logic        clock;
   logic        reset;
   logic [19:0] cpu_address;
   logic [7:0]  cpu_out;
   logic        cpu_we;
   logic [7:0]  cpu_in;
   logic        chipen;
   logic [19:0] mem_address;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        mem_req;
   logic [7:0]  mem_rdata;
   logic        mem_ack;
   logic        bus_error;

   int npass = 0;
   int ntot  = 0;

   // transaction-level model state
   logic [7:0]  cin_m = 8'h00;
   logic        err_m = 1'b0;
   logic        hv    = 1'b0;
   logic [19:0] ha    = '0;
   logic [7:0]  hd    = '0;

   k8088_bus #(.TIMEOUT(TMO)) dut (
      .clock       (clock),
      .reset       (reset),
      .cpu_address (cpu_address),
      .cpu_out     (cpu_out),
      .cpu_we      (cpu_we),
      .cpu_in      (cpu_in),
      .chipen      (chipen),
      .mem_address (mem_address),
      .mem_wdata   (mem_wdata),
      .mem_we      (mem_we),
      .mem_req     (mem_req),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack),
      .bus_error   (bus_error)
   );

   initial clock = 1'b0;
   always #20 clock = ~clock;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: got %0h expected %0h",
                  tag, obs, exp);
   endtask

   // One core step; entered and left at a negedge in IDLE.
   // n: ack in WAIT cycle n+1 (negative = never).
   task automatic step(input logic [19:0] a,
                       input logic [7:0]  d,
                       input logic        w,
                       input int          n,
                       input logic [7:0]  rd,
                       input logic        pre,
                       input logic        late);
      int         cyc;
      int         exp_clk;
      logic       hit;
      logic       tout;
      logic [7:0] exp_in;
      hit = 1'b0;
`ifdef K8088_BUS_HIT_EN
      hit = !w && hv && (a == ha);
`endif
      if (w && a == ha) hd = d;
      if (hit) begin
         exp_clk = 2;
         exp_in  = hd;
         tout    = 1'b0;
      end else if (n < 0 || n >= TMO) begin
         exp_clk = TMO + 2;
         exp_in  = 8'hFF;
         tout    = 1'b1;
      end else begin
         exp_clk = n + 3;
         exp_in  = w ? cin_m : rd;
         tout    = 1'b0;
      end
      cin_m = exp_in;
      if (tout) begin
         err_m = 1'b1;
         hv    = 1'b0;
      end else if (!w && !hit) begin
         hv = 1'b1;
         ha = a;
         hd = rd;
      end

      cpu_address = a;
      cpu_out     = d;
      cpu_we      = w;
      mem_rdata   = rd;
      mem_ack     = pre;
      for (cyc = 1; cyc <= 400; cyc++) begin
         @(negedge clock);
         if (chipen) break;
         chk("wait_bus",
             {mem_req, mem_we, mem_address, mem_wdata},
             {1'b1, w, a, d});
         mem_ack = (cyc - 1 == n);
      end
      if (cyc > 400) begin
         chk("chipen_timeout", 0, 1);
      end
      mem_ack = late;
      chk("clocks", cyc + 1, exp_clk);
      chk("cpu_in", cpu_in, exp_in);
      chk("bus_error", bus_error, err_m);
      chk("req_run", mem_req, 0);
      @(negedge clock);
      chk("chipen_once", chipen, 0);
      mem_ack = 1'b0;
   endtask

   initial begin
      logic [19:0] pool [4];
      logic [19:0] a;
      pool[0] = 20'h01234;
      pool[1] = 20'hFFFF0;
      pool[2] = 20'h00400;
      pool[3] = 20'h00000;

      reset       = 1'b0;
      cpu_address = '0;
      cpu_out     = '0;
      cpu_we      = 1'b0;
      mem_rdata   = '0;
      mem_ack     = 1'b0;
      #2 reset = 1'b1;
      @(negedge clock);
      chk("rst_outs",
          {chipen, mem_req, mem_we, bus_error, cpu_in}, 0);
      chk("rst_addr", {mem_address, mem_wdata}, 0);
      @(negedge clock);
      reset = 1'b0;

      step(20'hFFFF0, 8'h00, 1'b0, 0, 8'h5A, 1'b0, 1'b0);
      step(20'h00400, 8'h3C, 1'b1, 4, 8'hA5, 1'b0, 1'b0);
      step(20'h00123, 8'h00, 1'b0, TMO - 1, 8'h77, 1'b0, 1'b0);

      step(20'h01234, 8'h00, 1'b0, 0, 8'h11, 1'b0, 1'b0);
      step(20'h01234, 8'h00, 1'b0, 0, 8'h99, 1'b0, 1'b0);
      step(20'h01234, 8'h22, 1'b1, 0, 8'h00, 1'b0, 1'b0);
      step(20'h01234, 8'h00, 1'b0, 0, 8'h33, 1'b0, 1'b0);

      for (int i = 0; i < 30; i++) begin
         a = ($urandom_range(0, 3) == 0) ? 20'($urandom)
                                         : pool[$urandom_range(0, 3)];
         step(a, 8'($urandom), 1'($urandom),
              $urandom_range(0, TMO - 2), 8'($urandom),
              1'b0, 1'b0);
      end

      step(20'h00777, 8'h00, 1'b0, -1, 8'h44, 1'b0, 1'b1);
      step(20'h00777, 8'h00, 1'b0, 2, 8'h55, 1'b1, 1'b0);

      cpu_address = 20'h0ABCD;
      cpu_out     = 8'h5E;
      cpu_we      = 1'b1;
      mem_ack     = 1'b0;
      @(negedge clock);
      chk("req_before_rst", mem_req, 1);
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      chk("rst_async",
          {chipen, mem_req, bus_error, cpu_in}, 0);
      chk("rst_async_addr",
          {mem_we, mem_address, mem_wdata}, 0);
      @(negedge clock);
      reset = 1'b0;
      err_m = 1'b0;
      cin_m = 8'h00;
      hv    = 1'b0;
      step(20'h0ABCD, 8'h5E, 1'b1, 1, 8'h00, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         a = pool[$urandom_range(0, 3)];
         step(a, 8'($urandom), 1'($urandom),
              $urandom_range(0, TMO + 2), 8'($urandom),
              1'($urandom), 1'($urandom));
      end

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
